bus_rr_arbiter: RTL and testbench

Round-robin arbiter and router for the shared `devices`-port bus.
- Each device presents a first-word-fall-through output FIFO (`pndng`, `D_pop`).
- The arbiter grants one device at a time, pops one packet from it, decodes the destination ID in the packet header, and pushes the packet to the destination device's input, or to every other device on broadcast.
- It sits between the device FIFOs and the device inputs and is the only driver of `pop`/`push`.

---
 rtl/bus_pkg.sv | 14 +
 rtl/rr_picker.sv | 28 ++
 rtl/bus_rr_arbiter.sv | 113 +++++++++++
 tb/tb_bus_rr_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the device bus arbiter.
// Imported by the arbiter and its round-robin picker.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    ROUTE
  } arb_state_t;

  localparam int HDR_W = 8;
  localparam logic [HDR_W-1:0] BROADCAST = 8'hFF;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector.
// Searches from last+1 upward, wrapping at N.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] winner
);

  logic [IW-1:0] idx;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last) + k) % N);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter and packet router for the shared device bus.
// Grants one source, pops one word, pushes it to its destination(s).
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int               devices   = 4,
  parameter int               width     = 16,
  parameter logic [HDR_W-1:0] broadcast = BROADCAST
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [devices-1:0]                 pndng,
  input  logic [devices-1:0][width-1:0]      D_pop,
  output logic [devices-1:0]                 pop,
  output logic [devices-1:0]                 push,
  output logic [width-1:0]                   D_push,
  output logic [$clog2(devices)-1:0]         grant_id,
  output logic                               busy,
  output logic                               drop
);

  localparam int IW = $clog2(devices);

  arb_state_t state, nxt_state;

  logic [IW-1:0]      last, nxt_last;
  logic [IW-1:0]      nxt_gid;
  logic [devices-1:0] nxt_pop, nxt_push;
  logic               nxt_drop;
  logic [width-1:0]   pkt, nxt_pkt;
  logic [width-1:0]   word;
  logic [HDR_W-1:0]   dst;
  logic               is_bc, is_uni;
  logic               any;
  logic [IW-1:0]      winner;

  rr_picker #(
    .N  (devices),
    .IW (IW)
  ) u_pick (
    .req    (pndng),
    .last   (last),
    .any    (any),
    .winner (winner)
  );

  assign word   = D_pop[grant_id];
  assign dst    = word[width-1 -: HDR_W];
  assign is_bc  = (dst == broadcast);
  assign is_uni = !is_bc
               && (int'(dst) < devices)
               && (int'(dst) != int'(grant_id));
  assign D_push = pkt;

  // Route decision is made from the head word while popping,
  // so push/drop come straight out of flops during ROUTE.
  always_comb begin
    nxt_state = state;
    nxt_last  = last;
    nxt_gid   = grant_id;
    nxt_pop   = '0;
    nxt_push  = '0;
    nxt_drop  = 1'b0;
    nxt_pkt   = pkt;
    unique case (state)
      IDLE: begin
        if (any) begin
          nxt_state       = POP;
          nxt_gid         = winner;
          nxt_pop[winner] = 1'b1;
        end
      end
      POP: begin
        nxt_state = ROUTE;
        nxt_pkt   = word;
        nxt_last  = grant_id;
        unique case (1'b1)
          is_bc: begin
            nxt_push           = '1;
            nxt_push[grant_id] = 1'b0;
          end
          is_uni: nxt_push[dst[IW-1:0]] = 1'b1;
          default: nxt_drop = 1'b1;
        endcase
      end
      ROUTE:   nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= IW'(devices - 1);
      grant_id <= '0;
      pop      <= '0;
      push     <= '0;
      drop     <= 1'b0;
      pkt      <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= nxt_state;
      last     <= nxt_last;
      grant_id <= nxt_gid;
      pop      <= nxt_pop;
      push     <= nxt_push;
      drop     <= nxt_drop;
      pkt      <= nxt_pkt;
      busy     <= (nxt_state != IDLE);
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter.
// Transaction-level model plus directed literal checks.
module tb_bus_rr_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic [N-1:0]      pndng;
  logic [N-1:0][W-1:0] D_pop;
  logic [N-1:0]      pop;
  logic [N-1:0]      push;
  logic [W-1:0]      D_push;
  logic [1:0]        grant_id;
  logic              busy;
  logic              drop;

  int errors = 0;
  int checks = 0;

  bus_rr_arbiter #(
    .devices   (N),
    .width     (W),
    .broadcast (8'hFF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .grant_id (grant_id),
    .busy     (busy),
    .drop     (drop)
  );

  always #5 clk = ~clk;

  logic [W-1:0] q [N][$];

  int           m_phase = 0;
  int           m_last  = N - 1;
  int           m_gid   = 0;
  logic [N-1:0] e_pop   = '0;
  logic [N-1:0] e_push  = '0;
  logic         e_drop  = 1'b0;
  logic         e_busy  = 1'b0;
  logic [W-1:0] e_dpush = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      pndng[i] = (q[i].size() != 0);
      D_pop[i] = (q[i].size() != 0) ? q[i][0] : '0;
    end
  endtask

  task automatic load(int d, logic [W-1:0] w);
    q[d].push_back(w);
    refresh();
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_last  = N - 1;
    m_gid   = 0;
    e_pop   = '0;
    e_push  = '0;
    e_drop  = 1'b0;
    e_busy  = 1'b0;
    e_dpush = '0;
  endtask

  // One packet = grant, pop, route; phase counts the cycles left.
  task automatic model_step();
    int d;
    int dst;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_pop  = '0;
    e_push = '0;
    e_drop = 1'b0;
    if (m_phase == 0) begin
      for (int k = 1; k <= N; k++) begin
        d = (m_last + k) % N;
        if (e_pop == '0 && pndng[d]) begin
          m_gid    = d;
          e_pop[d] = 1'b1;
        end
      end
      if (e_pop != '0) m_phase = 2;
    end else if (m_phase == 2) begin
      e_dpush = D_pop[m_gid];
      dst     = int'(e_dpush[W-1 -: 8]);
      m_last  = m_gid;
      if (dst == 255) begin
        e_push        = '1;
        e_push[m_gid] = 1'b0;
      end else if (dst < N && dst != m_gid) begin
        e_push[dst] = 1'b1;
      end else begin
        e_drop = 1'b1;
      end
      m_phase = 1;
    end else begin
      m_phase = 0;
    end
    e_busy = (m_phase != 0);
  endtask

  task automatic step();
    logic [N-1:0] pm;
    @(negedge clk);
    chk("pop", 32'(pop), 32'(e_pop));
    chk("push", 32'(push), 32'(e_push));
    chk("drop", 32'(drop), 32'(e_drop));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("D_push", 32'(D_push), 32'(e_dpush));
    pm = pop;
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < N; i++)
      if (pm[i] && q[i].size() != 0) void'(q[i].pop_front());
    refresh();
  endtask

  task automatic wait_pop(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (pop == '0 && n < 12);
  endtask

  initial begin
    int n;
    int drops;
    logic [N-1:0] seen;
    logic acc;
    int order [5];
    order = '{0, 1, 2, 3, 0};
    pndng = '0;
    D_pop = '0;

    #1 rst_n = 1'b0;
    model_reset();
    repeat (3) step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_dpush", 32'(D_push), 0);
    rst_n = 1'b1;

    acc = 1'b0;
    repeat (20) begin
      step();
      acc = acc | (|pop) | (|push) | busy;
    end
    chk("idle_quiet", 32'(acc), 0);
    chk("idle_gid", 32'(grant_id), 0);

    load(1, 16'h0342);
    step();
    chk("uni_pop", 32'(pop), 32'h2);
    step();
    chk("uni_push", 32'(push), 32'h8);
    chk("uni_data", 32'(D_push), 32'h0342);
    chk("uni_drop", 32'(drop), 0);
    repeat (2) step();

    load(2, 16'hFF55);
    repeat (2) step();
    chk("bc_push", 32'(push), 32'hB);
    chk("bc_data", 32'(D_push), 32'hFF55);
    repeat (2) step();

    load(3, 16'h0133);
    repeat (2) step();
    chk("uni3_push", 32'(push), 32'h2);
    repeat (2) step();

    load(0, 16'h0100);
    load(0, 16'h0204);
    load(1, 16'h0201);
    load(2, 16'h0302);
    load(3, 16'h0003);
    for (int g = 0; g < 5; g++) begin
      wait_pop(n);
      chk("fair_gap", 32'(n), (g == 0) ? 1 : 3);
      chk("fair_gid", 32'(grant_id), 32'(order[g]));
    end
    repeat (3) step();

    load(0, 16'h0711);
    load(0, 16'h0022);
    drops = 0;
    seen  = '0;
    repeat (8) begin
      step();
      if (drop) drops++;
      seen = seen | push;
    end
    chk("inv_drops", 32'(drops), 2);
    chk("inv_push", 32'(seen), 0);

    load(2, 16'h0072);
    repeat (2) step();
    chk("mid_push", 32'(push), 32'h1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_push", 32'(push), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_drop", 32'(drop), 0);
    chk("arst_pop", 32'(pop), 0);
    repeat (2) step();
    rst_n = 1'b1;
    load(3, 16'h0013);
    load(0, 16'h0310);
    step();
    chk("post_rst_gid", 32'(grant_id), 0);
    chk("post_rst_pop", 32'(pop), 32'h1);
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
